// File: rtl/ungapped_xdrop_extender.sv
// ungapped_xdrop_extender
//   Ungapped X-drop extension scorer. Consumes one match/mismatch result per
//   beat, tracks the running and best scores, stops scoring once the running
//   score falls XDROP below the best (or the length cap is reached), drains the
//   rest of the window up to in_last, then strobes done with the result.
//
// Optional feature macro: XDROP_STATS_EN (adds term_xdrop / beats_used).
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           begin an extension (honoured only in IDLE)
//   in_valid/ready  beat handshake; in_match = 1 match / 0 mismatch
//   in_last         final position of the sequence window
//   busy            extension in progress (through the done cycle)
//   done            single-cycle result strobe
//   best_score      signed best score, held until the next start
//   best_len        beats up to and including the best position
//   hit             best_score >= THRESH, valid with done
//   term_xdrop      (XDROP_STATS_EN) ended by X-drop or length cap
//   beats_used      (XDROP_STATS_EN) beats scored before termination
module ungapped_xdrop_extender #(
  parameter int unsigned SCORE_W  = 12,
  parameter int unsigned POS_W    = 10,
  parameter int unsigned MATCH    = 2,
  parameter int unsigned MISMATCH = 1,
  parameter int unsigned XDROP    = 10,
  parameter int unsigned THRESH   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_match,
  input  logic                      in_last,
  output logic                      busy,
  output logic                      done,
  output logic signed [SCORE_W-1:0] best_score,
  output logic [POS_W-1:0]          best_len,
  output logic                      hit
`ifdef XDROP_STATS_EN
  ,
  output logic                      term_xdrop,
  output logic [POS_W-1:0]          beats_used
`endif
);

  // Two guard bits so sums and best-minus-new differences never wrap.
  localparam int unsigned EW = SCORE_W + 2;
  localparam logic signed [EW-1:0] SAT_HI   = EW'((2 ** (SCORE_W - 1)) - 1);
  localparam logic signed [EW-1:0] FLOOR_X  = -(EW'(XDROP) + EW'(MISMATCH));
  localparam logic signed [EW-1:0] MATCH_X  = EW'(MATCH);
  localparam logic signed [EW-1:0] MISM_X   = EW'(MISMATCH);
  localparam logic signed [EW-1:0] XDROP_X  = EW'(XDROP);
  localparam logic signed [EW-1:0] THRESH_X = EW'(THRESH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXTEND = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic signed [SCORE_W-1:0]  run_q, run_d;
  logic signed [SCORE_W-1:0]  best_q, best_d;
  logic [POS_W-1:0]           cnt_q, cnt_d;
  logic [POS_W-1:0]           len_q, len_d;
  logic                       hit_q, hit_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       rdy_q, rdy_d;
`ifdef XDROP_STATS_EN
  logic                       term_q, term_d;
  logic                       tx_q, tx_d;
  logic [POS_W-1:0]           used_q, used_d;
`endif

  logic signed [EW-1:0] run_x, best_x, sum_x, new_x, peak_x;
  logic                 upd_c, xdrop_c, cap_c, acc_c, fin_c;
  logic [POS_W-1:0]     cnt_inc;

  // Score of the current beat, clamped, and the termination test against
  // the best score as it stands after this beat.
  always_comb begin
    run_x  = EW'(run_q);
    best_x = EW'(best_q);
    sum_x  = in_match ? (run_x + MATCH_X) : (run_x - MISM_X);
    if (sum_x > SAT_HI) begin
      new_x = SAT_HI;
    end else if (sum_x < FLOOR_X) begin
      new_x = FLOOR_X;
    end else begin
      new_x = sum_x;
    end
    upd_c   = new_x > best_x;
    peak_x  = upd_c ? new_x : best_x;
    xdrop_c = (peak_x - new_x) >= XDROP_X;
    cnt_inc = cnt_q + POS_W'(1);
    cap_c   = &cnt_inc;
    acc_c   = in_valid && rdy_q;
  end

  // Next-state and result update.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    best_d  = best_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    hit_d   = hit_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rdy_d   = rdy_q;
    fin_c   = 1'b0;
`ifdef XDROP_STATS_EN
    term_d  = term_q;
    tx_d    = tx_q;
    used_d  = used_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          run_d   = '0;
          best_d  = '0;
          cnt_d   = '0;
          len_d   = '0;
          hit_d   = 1'b0;
          busy_d  = 1'b1;
          rdy_d   = 1'b1;
          state_d = S_EXTEND;
`ifdef XDROP_STATS_EN
          term_d  = 1'b0;
`endif
        end
      end
      S_EXTEND: begin
        if (acc_c) begin
          run_d = SCORE_W'(new_x);
          cnt_d = cnt_inc;
          if (upd_c) begin
            best_d = SCORE_W'(new_x);
            len_d  = cnt_inc;
          end
          // in_last wins over termination on the same beat.
          if (in_last) begin
            fin_c = 1'b1;
          end else if (xdrop_c || cap_c) begin
            state_d = S_DRAIN;
`ifdef XDROP_STATS_EN
            term_d  = 1'b1;
`endif
          end
        end
      end
      S_DRAIN: begin
        if (acc_c && in_last) begin
          fin_c = 1'b1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (fin_c) begin
      state_d = S_DONE;
      done_d  = 1'b1;
      rdy_d   = 1'b0;
      hit_d   = EW'(best_d) >= THRESH_X;
`ifdef XDROP_STATS_EN
      tx_d    = term_d;
      used_d  = cnt_d;
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      run_q   <= '0;
      best_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      hit_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
`ifdef XDROP_STATS_EN
      term_q  <= 1'b0;
      tx_q    <= 1'b0;
      used_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      best_q  <= best_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      hit_q   <= hit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
`ifdef XDROP_STATS_EN
      term_q  <= term_d;
      tx_q    <= tx_d;
      used_q  <= used_d;
`endif
    end
  end

  assign in_ready   = rdy_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign best_score = best_q;
  assign best_len   = len_q;
  assign hit        = hit_q;
`ifdef XDROP_STATS_EN
  assign term_xdrop = tx_q;
  assign beats_used = used_q;
`endif

endmodule

// File: tb/tb_ungapped_xdrop_extender.sv
// Self-checking bench for ungapped_xdrop_extender: directed windows from the
// block's intended use plus randomized windows, each scored by a plain
// integer reference model of the X-drop rules.
module tb_ungapped_xdrop_extender;

  localparam int SCORE_W  = 12;
  localparam int POS_W    = 10;
  localparam int MATCH    = 2;
  localparam int MISMATCH = 1;
  localparam int XDROP    = 10;
  localparam int THRESH   = 16;
  localparam int SAT_HI   = (2 ** (SCORE_W - 1)) - 1;
  localparam int LEN_CAP  = (2 ** POS_W) - 1;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      start = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      in_match = 1'b0;
  logic                      in_last = 1'b0;
  logic                      in_ready;
  logic                      busy;
  logic                      done;
  logic signed [SCORE_W-1:0] best_score;
  logic [POS_W-1:0]          best_len;
  logic                      hit;
`ifdef XDROP_STATS_EN
  logic                      term_xdrop;
  logic [POS_W-1:0]          beats_used;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit seq_m[$];

  ungapped_xdrop_extender dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_match   (in_match),
    .in_last    (in_last),
    .busy       (busy),
    .done       (done),
    .best_score (best_score),
    .best_len   (best_len),
    .hit        (hit)
`ifdef XDROP_STATS_EN
    ,
    .term_xdrop (term_xdrop),
    .beats_used (beats_used)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_n(input bit m, input int n);
    for (int i = 0; i < n; i++) seq_m.push_back(m);
  endtask

  // Reference: score the window beat by beat; in_last is the final beat.
  task automatic model(output int e_best, output int e_len, output int e_hit,
                       output int e_term, output int e_used);
    int  run, nv, cnt, last;
    bit  stop;
    run = 0; e_best = 0; e_len = 0; cnt = 0; stop = 0; e_term = 0;
    last = seq_m.size() - 1;
    for (int i = 0; i <= last; i++) begin
      if (!stop) begin
        nv = seq_m[i] ? run + MATCH : run - MISMATCH;
        if (nv > SAT_HI) nv = SAT_HI;
        if (nv < -(XDROP + MISMATCH)) nv = -(XDROP + MISMATCH);
        run = nv;
        cnt = cnt + 1;
        if (nv > e_best) begin
          e_best = nv;
          e_len  = cnt;
        end
        if (i != last && (e_best - nv >= XDROP || cnt == LEN_CAP)) begin
          stop   = 1;
          e_term = 1;
        end
      end
    end
    e_hit  = (e_best >= THRESH) ? 1 : 0;
    e_used = cnt;
  endtask

  // Run one extension over seq_m; gaps inserts an idle beat (with a stray
  // start pulse) before every valid beat.
  task automatic run_seq(input string tag, input bit gaps);
    int e_best, e_len, e_hit, e_term, e_used;
    int early;
    model(e_best, e_len, e_hit, e_term, e_used);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, ":busy_start"}, 32'(busy), 1);
    chk({tag, ":rdy_start"}, 32'(in_ready), 1);
    early = 0;
    for (int i = 0; i < seq_m.size(); i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        start    = 1'b1;
        in_match = 1'($urandom_range(0, 1));
        step();
        start = 1'b0;
        if (done !== 1'b0) early++;
      end
      in_valid = 1'b1;
      in_match = seq_m[i];
      in_last  = (i == seq_m.size() - 1);
      step();
      if (i != seq_m.size() - 1 && done !== 1'b0) early++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({tag, ":early_done"}, early, 0);
    chk({tag, ":done"}, 32'(done), 1);
    chk({tag, ":best"}, 32'(best_score), e_best);
    chk({tag, ":len"}, 32'(best_len), e_len);
    chk({tag, ":hit"}, 32'(hit), e_hit);
`ifdef XDROP_STATS_EN
    chk({tag, ":term"}, 32'(term_xdrop), e_term);
    chk({tag, ":used"}, 32'(beats_used), e_used);
`endif
    step();
    chk({tag, ":done_drop"}, 32'(done), 0);
    chk({tag, ":busy_drop"}, 32'(busy), 0);
    chk({tag, ":rdy_drop"}, 32'(in_ready), 0);
    chk({tag, ":best_held"}, 32'(best_score), e_best);
    chk({tag, ":len_held"}, 32'(best_len), e_len);
    step();
  endtask

  initial begin
    int n;
    // Reset values.
    step();
    step();
    chk("rst:rdy", 32'(in_ready), 0);
    chk("rst:busy", 32'(busy), 0);
    chk("rst:done", 32'(done), 0);
    chk("rst:hit", 32'(hit), 0);
    chk("rst:best", 32'(best_score), 0);
    chk("rst:len", 32'(best_len), 0);
`ifdef XDROP_STATS_EN
    chk("rst:term", 32'(term_xdrop), 0);
    chk("rst:used", 32'(beats_used), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Eight matches.
    seq_m.delete();
    push_n(1'b1, 8);
    run_seq("all_match", 1'b0);
    chk("all_match:best_lit", 32'(best_score), 16);

    // X-drop then drain three beats.
    seq_m.delete();
    push_n(1'b1, 5);
    push_n(1'b0, 10);
    push_n(1'b1, 2);
    push_n(1'b0, 1);
    run_seq("xdrop_drain", 1'b0);
    chk("xdrop_drain:len_lit", 32'(best_len), 5);

    // Tie keeps the earlier position.
    seq_m.delete();
    push_n(1'b1, 1);
    push_n(1'b0, 2);
    push_n(1'b1, 1);
    run_seq("tie", 1'b0);
    chk("tie:len_lit", 32'(best_len), 1);

    // Termination on the in_last beat goes straight to done.
    seq_m.delete();
    push_n(1'b1, 5);
    push_n(1'b0, 10);
    run_seq("xdrop_last", 1'b0);

    // Same drain window with gaps and stray start pulses.
    seq_m.delete();
    push_n(1'b1, 5);
    push_n(1'b0, 10);
    push_n(1'b1, 2);
    push_n(1'b0, 1);
    run_seq("gaps", 1'b1);

    // Length cap.
    seq_m.delete();
    push_n(1'b1, LEN_CAP + 7);
    run_seq("cap", 1'b0);

    // Randomized windows.
    for (int r = 0; r < 20; r++) begin
      seq_m.delete();
      n = $urandom_range(1, 60);
      for (int i = 0; i < n; i++) seq_m.push_back($urandom_range(0, 99) < 65);
      run_seq($sformatf("rand%0d", r), 1'($urandom_range(0, 1)));
    end

    // in_valid in IDLE is not accepted.
    in_valid = 1'b1;
    in_match = 1'b1;
    step();
    chk("idle:rdy", 32'(in_ready), 0);
    chk("idle:busy", 32'(busy), 0);
    in_valid = 1'b0;
    step();

    // Reset mid-extension.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_match = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst:best", 32'(best_score), 0);
    chk("midrst:len", 32'(best_len), 0);
    chk("midrst:busy", 32'(busy), 0);
    chk("midrst:rdy", 32'(in_ready), 0);
    chk("midrst:hit", 32'(hit), 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done !== 1'b0) n++;
    end
    chk("midrst:no_done", n, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    seq_m.delete();
    push_n(1'b1, 2);
    run_seq("post_rst", 1'b0);
    chk("post_rst:best_lit", 32'(best_score), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
